game_outcome: RTL and testbench
===============================

# game_outcome

Match-outcome tracker that sits directly upstream of the end-of-game overlay stage. It counts hits on the player tank and the opponent tank, decides win/lose, and drives the 2-bit `game_end` code the overlay consumes. It also returns to idle when the overlay raises `back_to_menu`. `game_end` changes only at a vertical-blank start, so the overlay never switches mid-frame.

## Interface
- `HP_INIT`, default 3: hit points each tank starts with; must be in 1..2^HP_W-1.
- `HP_W`, default 2: width of the hit-point counters.
- `INVULN_CYCLES`, default 65_000_000: post-hit immunity window in clk cycles, 1 s at 65 MHz; must be ≥1.
- `clk`  in  1  pixel clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `select`  in  1  game mode active; 0 means menu is shown.
- `vblnk`  in  1  vertical blank from the timing chain.
- `hit_player`  in  1  own tank hit; rising-edge detected internally.
- `hit_enemy`  in  1  opponent tank hit; rising-edge detected internally.
- `back_to_menu`  in  1  one-cycle pulse from the end-game overlay.
- `game_end`  out  2  0 = playing/idle, 1 = win, 2 = lose; 3 never driven.
- `hp_player`  out  HP_W  remaining player hit points.
- `hp_enemy`  out  HP_W  remaining opponent hit points.

## Operation
- **States:** IDLE, PLAY, WIN_PEND, LOSE_PEND, WIN, LOSE.
- **Hit edge:** an edge on input X is `X=1` while the registered copy `X_q=0`. Edge registers reset to 0.
- **IDLE:** HP counters are held at HP_INIT and `game_end`=0. Leave to PLAY when `select`=1.
- **PLAY:** a hit edge on a tank decrements that tank's HP by 1 if it is not immune.
  - HP saturates at 0.
  - On the decrement, that tank's immunity counter loads INVULN_CYCLES.
- **HP reaches 0 in PLAY:**
  - `hp_player` becomes 0 → LOSE_PEND.
  - Else `hp_enemy` becomes 0 → WIN_PEND.
  - Both reach 0 on the same edge → LOSE_PEND (a draw counts as a loss).
- **WIN_PEND / LOSE_PEND:** HP is frozen and further hits are ignored.
  - On a vblnk rising edge (`vblnk`=1, `vblnk_q`=0) go to WIN/LOSE and set `game_end` to 1/2 on that same edge.
- **WIN / LOSE:** hold `game_end`. On `back_to_menu`=1 go to IDLE, reload both HP counters to HP_INIT, and clear `game_end` to 0 on that edge.
- **`select`=0 in any non-IDLE state:** forces IDLE on the next edge, with HP reload and `game_end`=0. This takes priority over every other transition.
- **Immunity counters:** decrement by 1 per cycle down to 0; a tank is immune while its counter is nonzero. Counters clear in IDLE.
- **Simultaneous hit edges on both tanks:** both are processed on the same edge, each against its own immunity.

## Timing
- **Reset values:** state=IDLE, `game_end`=0, `hp_player`=`hp_enemy`=HP_INIT, immunity counters=0, edge registers=0.
- **Hit latency:** the HP output changes on the first clk edge that samples the hit edge (1-cycle latency from input change).
- **Immunity window:** a hit sampled at edge N blocks hit edges on that tank at edges N+1..N+INVULN_CYCLES. A hit edge at N+INVULN_CYCLES+1 is accepted.
- **Outcome latency:**
  - `game_end` updates at the first vblnk rising edge strictly after the edge that entered *_PEND.
  - If vblnk rises on the same edge that HP hits 0, wait for the next frame's rising edge.
- **`back_to_menu`:** honoured only in WIN/LOSE and ignored elsewhere. `game_end`=0 one cycle after the pulse.
- **Reset mid-operation:** all outputs return asynchronously to their reset values.

## Configuration
- **`GAME_OUTCOME_INVULN_EN` defined:** immunity counters are built as described.
- **Undefined:** no immunity counters; every accepted hit edge in PLAY decrements HP; `INVULN_CYCLES` is ignored.

## Test plan
- Tests use `HP_INIT`=3, `INVULN_CYCLES`=8, macro defined unless noted.
- **Win path:**
  - Stimulus: `select`=1; three `hit_enemy` edges spaced 10 cycles apart.
  - Response: `hp_enemy` steps 3→2→1→0 one cycle after each edge.
  - Response: `game_end` stays 0 until the next vblnk rise, then becomes 1.
  - Stimulus: `back_to_menu` pulse.
  - Response: `game_end`=0 and both HP=3 next cycle.
- **Immunity:**
  - Stimulus: `hit_player` edges at cycles 0, 4, 9.
  - Response: `hp_player` is 2 after 0, still 2 after 4, and 1 after 9.
  - Stimulus: same sequence without the macro.
  - Response: `hp_player` ends at 0 and LOSE follows at the next vblnk rise.
- **Draw:**
  - Stimulus: both HP at 1; `hit_player` and `hit_enemy` edges on the same cycle.
  - Response: both HP=0; `game_end`=2 at the next vblnk rise.
- **Abort:**
  - Stimulus: in LOSE_PEND, drop `select` to 0 before the vblnk rise.
  - Response: IDLE next cycle; `game_end` never leaves 0; HP reloads to 3.
- **Held input:**
  - Stimulus: `hit_enemy` held high for 50 cycles.
  - Response: exactly one decrement (3→2).
- **Async reset:**
  - Stimulus: in WIN with `game_end`=1, assert `rst` between clock edges.
  - Response: `game_end`=0 and HP=3 immediately, before the next clk edge.

Source files
------------

// File: rtl/game_outcome_if.sv
// Match-outcome bus between the game logic and the game_outcome tracker.
// master: the side that drives the game inputs and reads the outcome.
// slave:  the tracker itself.
interface game_outcome_if #(
  parameter int unsigned HP_W = 2
);
  logic            select;
  logic            vblnk;
  logic            hit_player;
  logic            hit_enemy;
  logic            back_to_menu;
  logic [1:0]      game_end;
  logic [HP_W-1:0] hp_player;
  logic [HP_W-1:0] hp_enemy;

  modport master (
    output select, vblnk, hit_player, hit_enemy, back_to_menu,
    input  game_end, hp_player, hp_enemy
  );

  modport slave (
    input  select, vblnk, hit_player, hit_enemy, back_to_menu,
    output game_end, hp_player, hp_enemy
  );
endinterface

// File: rtl/game_outcome.sv
// Match-outcome tracker: counts hits on both tanks, decides win/lose and
// drives the game_end code for the end-of-game overlay. game_end only
// changes on a vblnk rising edge so the overlay never switches mid-frame.
// Optional feature macro: GAME_OUTCOME_INVULN_EN builds the post-hit
// immunity counters; without it every hit edge in play decrements HP.
module game_outcome #(
  parameter int unsigned HP_INIT       = 3,
  parameter int unsigned HP_W          = 2,
  parameter int unsigned INVULN_CYCLES = 65_000_000
) (
  input logic             clk,
  input logic             rst,
  game_outcome_if.slave   bus
);

  localparam logic [HP_W-1:0] HpInit = HP_INIT[HP_W-1:0];
  localparam logic [1:0] GeNone = 2'd0;
  localparam logic [1:0] GeWin  = 2'd1;
  localparam logic [1:0] GeLose = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StPlay,
    StWinPend,
    StLosePend,
    StWin,
    StLose
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      game_end_q, game_end_d;
  logic [HP_W-1:0] hp_player_q, hp_player_d;
  logic [HP_W-1:0] hp_enemy_q, hp_enemy_d;
  logic            hit_player_q, hit_enemy_q, vblnk_q;

  logic player_edge, enemy_edge, vblnk_rise;
  logic player_immune, enemy_immune;
  logic player_load, enemy_load, imm_clear;

  assign player_edge = bus.hit_player & ~hit_player_q;
  assign enemy_edge  = bus.hit_enemy & ~hit_enemy_q;
  assign vblnk_rise  = bus.vblnk & ~vblnk_q;

`ifdef GAME_OUTCOME_INVULN_EN
  localparam int unsigned ImmW = $clog2(INVULN_CYCLES + 1);
  localparam logic [ImmW-1:0] ImmLoad = ImmW'(INVULN_CYCLES);

  logic [ImmW-1:0] imm_player_q, imm_player_d;
  logic [ImmW-1:0] imm_enemy_q, imm_enemy_d;

  // Immunity counters: clear in idle, reload on an accepted hit, else count down.
  always_comb begin
    imm_player_d = imm_player_q;
    imm_enemy_d  = imm_enemy_q;
    if (imm_clear) begin
      imm_player_d = '0;
      imm_enemy_d  = '0;
    end else begin
      if (player_load) begin
        imm_player_d = ImmLoad;
      end else if (imm_player_q != '0) begin
        imm_player_d = imm_player_q - ImmW'(1);
      end
      if (enemy_load) begin
        imm_enemy_d = ImmLoad;
      end else if (imm_enemy_q != '0) begin
        imm_enemy_d = imm_enemy_q - ImmW'(1);
      end
    end
  end

  // Immunity counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_player_q <= '0;
      imm_enemy_q  <= '0;
    end else begin
      imm_player_q <= imm_player_d;
      imm_enemy_q  <= imm_enemy_d;
    end
  end

  assign player_immune = (imm_player_q != '0);
  assign enemy_immune  = (imm_enemy_q != '0);
`else
  assign player_immune = 1'b0;
  assign enemy_immune  = 1'b0;

  logic unused_imm;
  assign unused_imm = ^{player_load, enemy_load, imm_clear, INVULN_CYCLES[0]};
`endif

  // Registered copies of the inputs for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_player_q <= 1'b0;
      hit_enemy_q  <= 1'b0;
      vblnk_q      <= 1'b0;
    end else begin
      hit_player_q <= bus.hit_player;
      hit_enemy_q  <= bus.hit_enemy;
      vblnk_q      <= bus.vblnk;
    end
  end

  // Next-state, HP and outcome decode; dropping select overrides everything.
  always_comb begin
    state_d     = state_q;
    game_end_d  = game_end_q;
    hp_player_d = hp_player_q;
    hp_enemy_d  = hp_enemy_q;
    player_load = 1'b0;
    enemy_load  = 1'b0;
    imm_clear   = 1'b0;

    if (state_q != StIdle && !bus.select) begin
      state_d     = StIdle;
      game_end_d  = GeNone;
      hp_player_d = HpInit;
      hp_enemy_d  = HpInit;
      imm_clear   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          game_end_d  = GeNone;
          hp_player_d = HpInit;
          hp_enemy_d  = HpInit;
          imm_clear   = 1'b1;
          if (bus.select) begin
            state_d = StPlay;
          end
        end
        StPlay: begin
          if (player_edge && !player_immune) begin
            player_load = 1'b1;
            if (hp_player_q != '0) begin
              hp_player_d = hp_player_q - HP_W'(1);
            end
          end
          if (enemy_edge && !enemy_immune) begin
            enemy_load = 1'b1;
            if (hp_enemy_q != '0) begin
              hp_enemy_d = hp_enemy_q - HP_W'(1);
            end
          end
          // A simultaneous knockout is a draw, which counts as a loss.
          if (hp_player_d == '0) begin
            state_d = StLosePend;
          end else if (hp_enemy_d == '0) begin
            state_d = StWinPend;
          end
        end
        StWinPend: begin
          if (vblnk_rise) begin
            state_d    = StWin;
            game_end_d = GeWin;
          end
        end
        StLosePend: begin
          if (vblnk_rise) begin
            state_d    = StLose;
            game_end_d = GeLose;
          end
        end
        StWin, StLose: begin
          if (bus.back_to_menu) begin
            state_d     = StIdle;
            game_end_d  = GeNone;
            hp_player_d = HpInit;
            hp_enemy_d  = HpInit;
            imm_clear   = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State, HP and outcome registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      game_end_q  <= GeNone;
      hp_player_q <= HpInit;
      hp_enemy_q  <= HpInit;
    end else begin
      state_q     <= state_d;
      game_end_q  <= game_end_d;
      hp_player_q <= hp_player_d;
      hp_enemy_q  <= hp_enemy_d;
    end
  end

  assign bus.game_end  = game_end_q;
  assign bus.hp_player = hp_player_q;
  assign bus.hp_enemy  = hp_enemy_q;

endmodule

// File: tb/tb_game_outcome.sv
// Bench for game_outcome: a timestamp-based reference model predicts the
// outputs each cycle into a scoreboard queue, popped after the clock edge.
module tb_game_outcome;

  localparam int unsigned Hp  = 3;
  localparam int unsigned Inv = 8;

  localparam int MIdle  = 0;
  localparam int MPlay  = 1;
  localparam int MWPend = 2;
  localparam int MLPend = 3;
  localparam int MWin   = 4;
  localparam int MLose  = 5;

  logic clk = 1'b0;
  logic rst;

  game_outcome_if #(.HP_W(2)) bus ();

  game_outcome #(
    .HP_INIT      (Hp),
    .HP_W         (2),
    .INVULN_CYCLES(Inv)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ge;
    int hpp;
    int hpe;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  int m_state, m_ge, m_hp_p, m_hp_e, m_cyc, m_last_p, m_last_e;
  bit m_pq, m_eq, m_vq;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_init();
    m_state  = MIdle;
    m_ge     = 0;
    m_hp_p   = Hp;
    m_hp_e   = Hp;
    m_cyc    = 0;
    m_last_p = -1000;
    m_last_e = -1000;
    m_pq     = 0;
    m_eq     = 0;
    m_vq     = 0;
  endtask

  function automatic bit immune(input int last);
`ifdef GAME_OUTCOME_INVULN_EN
    return (m_cyc - last) <= int'(Inv);
`else
    return (last != last);
`endif
  endfunction

  task automatic model_idle();
    m_state  = MIdle;
    m_ge     = 0;
    m_hp_p   = Hp;
    m_hp_e   = Hp;
    m_last_p = -1000;
    m_last_e = -1000;
  endtask

  // Predict the outputs after the coming clock edge from the current inputs.
  task automatic model_step();
    bit pe, ee, ve;
    exp_t e;
    pe = bus.hit_player && !m_pq;
    ee = bus.hit_enemy && !m_eq;
    ve = bus.vblnk && !m_vq;
    m_pq = bus.hit_player;
    m_eq = bus.hit_enemy;
    m_vq = bus.vblnk;
    m_cyc++;
    if (m_state != MIdle && !bus.select) begin
      model_idle();
    end else begin
      case (m_state)
        MIdle: begin
          model_idle();
          if (bus.select) m_state = MPlay;
        end
        MPlay: begin
          if (pe && !immune(m_last_p)) begin
            if (m_hp_p > 0) m_hp_p--;
            m_last_p = m_cyc;
          end
          if (ee && !immune(m_last_e)) begin
            if (m_hp_e > 0) m_hp_e--;
            m_last_e = m_cyc;
          end
          if (m_hp_p == 0) m_state = MLPend;
          else if (m_hp_e == 0) m_state = MWPend;
        end
        MWPend: if (ve) begin m_state = MWin; m_ge = 1; end
        MLPend: if (ve) begin m_state = MLose; m_ge = 2; end
        default: if (bus.back_to_menu) model_idle();
      endcase
    end
    e.ge  = m_ge;
    e.hpp = m_hp_p;
    e.hpe = m_hp_e;
    sb_q.push_back(e);
  endtask

  // One clock: predict, let the edge happen, compare, return at the negedge.
  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    check_val("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("game_end", bus.game_end, e.ge);
      check_val("hp_player", bus.hp_player, e.hpp);
      check_val("hp_enemy", bus.hp_enemy, e.hpe);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst              = 1'b1;
    bus.select       = 1'b0;
    bus.vblnk        = 1'b0;
    bus.hit_player   = 1'b0;
    bus.hit_enemy    = 1'b0;
    bus.back_to_menu = 1'b0;
    model_init();
    #2;
    check_val("rst_game_end", bus.game_end, 0);
    check_val("rst_hp_player", bus.hp_player, Hp);
    check_val("rst_hp_enemy", bus.hp_enemy, Hp);
    @(negedge clk);
    rst = 1'b0;
    run(2);

    // Win path
    bus.select = 1'b1;
    cycle();
    for (int k = 1; k <= 3; k++) begin
      bus.hit_enemy = 1'b1;
      cycle();
      check_val("win_hp_step", bus.hp_enemy, Hp - k);
      bus.hit_enemy = 1'b0;
      run(9);
    end
    check_val("win_pend_ge", bus.game_end, 0);
    bus.vblnk = 1'b1;
    cycle();
    check_val("win_ge", bus.game_end, 1);
    bus.vblnk = 1'b0;
    run(2);
    bus.back_to_menu = 1'b1;
    cycle();
    bus.back_to_menu = 1'b0;
    check_val("menu_ge", bus.game_end, 0);
    check_val("menu_hp_enemy", bus.hp_enemy, Hp);

    // Immunity: player hit edges at relative cycles 0, 4, 9
    cycle();
    bus.hit_player = 1'b1;
    cycle();
    check_val("imm_hit0", bus.hp_player, 2);
    bus.hit_player = 1'b0;
    run(3);
    bus.hit_player = 1'b1;
    cycle();
`ifdef GAME_OUTCOME_INVULN_EN
    check_val("imm_hit4", bus.hp_player, 2);
`else
    check_val("imm_hit4", bus.hp_player, 1);
`endif
    bus.hit_player = 1'b0;
    run(4);
    bus.hit_player = 1'b1;
    cycle();
`ifdef GAME_OUTCOME_INVULN_EN
    check_val("imm_hit9", bus.hp_player, 1);
    bus.hit_player = 1'b0;
    run(10);
    bus.hit_player = 1'b1;
    cycle();
`endif
    check_val("imm_final", bus.hp_player, 0);
    bus.hit_player = 1'b0;

    // Abort from LOSE_PEND before any vblnk rise
    run(2);
    bus.select = 1'b0;
    cycle();
    check_val("abort_ge", bus.game_end, 0);
    check_val("abort_hp", bus.hp_player, Hp);
    run(2);

    // Draw, with vblnk rising on the knockout edge itself
    bus.select = 1'b1;
    cycle();
    for (int k = 1; k <= 3; k++) begin
      bus.hit_player = 1'b1;
      bus.hit_enemy  = 1'b1;
      if (k == 3) bus.vblnk = 1'b1;
      cycle();
      check_val("draw_hp_p", bus.hp_player, Hp - k);
      check_val("draw_hp_e", bus.hp_enemy, Hp - k);
      bus.hit_player = 1'b0;
      bus.hit_enemy  = 1'b0;
      if (k < 3) run(9);
    end
    run(3);
    check_val("draw_wait_ge", bus.game_end, 0);
    bus.vblnk = 1'b0;
    cycle();
    bus.vblnk = 1'b1;
    cycle();
    check_val("draw_ge", bus.game_end, 2);
    bus.vblnk = 1'b0;
    cycle();
    bus.back_to_menu = 1'b1;
    cycle();
    bus.back_to_menu = 1'b0;
    check_val("draw_menu_ge", bus.game_end, 0);

    // Held input plus an ignored back_to_menu in PLAY
    cycle();
    bus.back_to_menu = 1'b1;
    cycle();
    bus.back_to_menu = 1'b0;
    bus.hit_enemy = 1'b1;
    run(50);
    bus.hit_enemy = 1'b0;
    check_val("held_hp_e", bus.hp_enemy, 2);
    check_val("held_hp_p", bus.hp_player, Hp);

    // Reach WIN, then assert reset between clock edges
    run(10);
    for (int k = 0; k < 2; k++) begin
      bus.hit_enemy = 1'b1;
      cycle();
      bus.hit_enemy = 1'b0;
      run(9);
    end
    bus.vblnk = 1'b1;
    cycle();
    bus.vblnk = 1'b0;
    check_val("pre_rst_ge", bus.game_end, 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_ge", bus.game_end, 0);
    check_val("async_hp_p", bus.hp_player, Hp);
    check_val("async_hp_e", bus.hp_enemy, Hp);
    model_init();
    @(negedge clk);
    rst = 1'b0;
    run(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
